// File: rtl/biu_master.sv
// Single-beat bus master: accepts one client read/write, arbitrates for the bus,
// runs address and wait phases, and returns data/error with a one-cycle biu_done pulse.
module biu_master #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 16,
    parameter int ALIGNED    = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    biu_en,
    input  logic                    biu_rnw,
    input  logic [ADDR_WIDTH-1:0]   biu_address,
    input  logic [DATA_WIDTH-1:0]   biu_data_in,
    input  logic [DATA_WIDTH/8-1:0] biu_byte_en,
    output logic                    biu_ready,
    output logic [DATA_WIDTH-1:0]   biu_data_out,
    output logic                    biu_done,
    output logic                    biu_err,
    output logic                    bus_req,
    input  logic                    bus_gnt,
    output logic                    bus_valid,
    output logic                    bus_rnw,
    output logic [ADDR_WIDTH-1:0]   bus_address,
    output logic [DATA_WIDTH/8-1:0] bus_byte_en,
    output logic [DATA_WIDTH-1:0]   bus_data_out,
    output logic                    bus_data_oe,
    input  logic [DATA_WIDTH-1:0]   bus_data_in,
    input  logic                    bus_ack,
    input  logic                    bus_err
);

    localparam int BE_WIDTH = DATA_WIDTH / 8;
    localparam int CNT_W    = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0]      TO_VAL     = CNT_W'(TIMEOUT);
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ADDR_WIDTH'(BE_WIDTH - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_ADDR,
        S_WAIT,
        S_RESP
    } state_t;

    state_t                  state_q, state_d;
    logic                    rnw_q, rnw_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic [BE_WIDTH-1:0]     be_q, be_d;
    logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
    logic                    err_q, err_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [CNT_W-1:0]        cnt_inc;
    logic                    misaligned;
    logic                    on_bus;

    assign cnt_inc    = cnt_q + 1'b1;
    assign misaligned = (ALIGNED != 0) && ((biu_address & ALIGN_MASK) != '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            rnw_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            rnw_q   <= rnw_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            be_q    <= be_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        rnw_d   = rnw_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        be_d    = be_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            S_IDLE: begin
                if (biu_en) begin
                    rnw_d   = biu_rnw;
                    addr_d  = biu_address;
                    wdata_d = biu_data_in;
                    be_d    = biu_byte_en;
                    // Misaligned requests never touch the bus.
                    err_d   = misaligned;
                    state_d = misaligned ? S_RESP : S_REQ;
                end
            end
            S_REQ: begin
                if (bus_gnt) begin
                    state_d = S_ADDR;
                end
            end
            S_ADDR: begin
                cnt_d   = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                // An acknowledge beats a timeout expiring in the same cycle.
                if (bus_ack) begin
                    err_d   = bus_err;
                    state_d = S_RESP;
                    if (rnw_q) begin
                        rdata_d = bus_data_in;
                    end
                end else begin
                    cnt_d = cnt_inc;
                    if ((TIMEOUT != 0) && (cnt_inc == TO_VAL)) begin
                        err_d   = 1'b1;
                        state_d = S_RESP;
                        if (rnw_q) begin
                            rdata_d = '0;
                        end
                    end
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Bus outputs are forced to zero when not owning the bus so they can be wire-ORed.
    assign on_bus       = (state_q == S_ADDR) || (state_q == S_WAIT);
    assign biu_ready    = (state_q == S_IDLE);
    assign biu_done     = (state_q == S_RESP);
    assign biu_err      = (state_q == S_RESP) && err_q;
    assign biu_data_out = rdata_q;
    assign bus_req      = (state_q == S_REQ) || on_bus;
    assign bus_valid    = (state_q == S_ADDR);
    assign bus_rnw      = on_bus && rnw_q;
    assign bus_address  = on_bus ? addr_q : '0;
    assign bus_byte_en  = on_bus ? (rnw_q ? {BE_WIDTH{1'b1}} : be_q) : '0;
    assign bus_data_oe  = on_bus && !rnw_q;
    assign bus_data_out = (on_bus && !rnw_q) ? wdata_q : '0;

endmodule
